// File: rtl/rr_mux8to1.sv
// Eight-channel round-robin TDM multiplexer: arbitrates per-channel requests and
// presents one captured word at a time as (Y, sel) under a valid/ready handshake.
module rr_mux8to1 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*DATA_W-1:0]   D,
    input  logic [7:0]            req,
    output logic [7:0]            ack,
    output logic [DATA_W-1:0]     Y,
    output logic [2:0]            sel,
    output logic                  valid,
    input  logic                  ready,
    output logic [15:0]           xfer_cnt
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e              r_state;
    logic [2:0]          r_ptr;
    logic [DATA_W-1:0]   r_y;
    logic [2:0]          r_sel;
    logic [7:0]          r_ack;
    logic [15:0]         r_cnt;

    state_e              w_state_nxt;
    logic [2:0]          w_ptr_nxt;
    logic [DATA_W-1:0]   w_y_nxt;
    logic [2:0]          w_sel_nxt;
    logic [7:0]          w_ack_nxt;
    logic [15:0]         w_cnt_nxt;

    logic                w_accept;
    logic [2:0]          w_base;
    logic [2:0]          w_idx;
    logic [2:0]          w_win;
    logic                w_found;

    always_comb begin
        w_accept = (r_state == StHold) && ready;
        // On an accept edge the search starts just past the channel being retired.
        w_base   = w_accept ? r_sel + 3'd1 : r_ptr;

        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 3'd0;
        // Scan farthest offset first so the nearest requester overwrites the result.
        for (int k = 7; k >= 0; k--) begin
            w_idx = w_base + 3'(k);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end

        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_y_nxt     = r_y;
        w_sel_nxt   = r_sel;
        w_ack_nxt   = 8'd0;
        w_cnt_nxt   = r_cnt;

        if (w_accept) begin
            w_ptr_nxt   = r_sel + 3'd1;
            w_cnt_nxt   = r_cnt + 16'd1;
            w_state_nxt = StIdle;
        end

        if (((r_state == StIdle) || w_accept) && w_found) begin
            w_y_nxt     = D[w_win*DATA_W +: DATA_W];
            w_sel_nxt   = w_win;
            w_ack_nxt   = 8'd1 << w_win;
            w_state_nxt = StHold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= 3'd0;
            r_y     <= '0;
            r_sel   <= 3'd0;
            r_ack   <= 8'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_y     <= w_y_nxt;
            r_sel   <= w_sel_nxt;
            r_ack   <= w_ack_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign valid    = (r_state == StHold);
    assign Y        = r_y;
    assign sel      = r_sel;
    assign ack      = r_ack;
    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_rr_mux8to1.sv
// Bench for rr_mux8to1: directed vector table, hand sequences for reset, backpressure,
// pointer and counter wrap, then randomized traffic against a behavioural model.
module tb_rr_mux8to1;

    logic        clk;
    logic        rst;
    logic [7:0]  D;
    logic [7:0]  req;
    logic [7:0]  ack;
    logic [0:0]  Y;
    logic [2:0]  sel;
    logic        valid;
    logic        ready;
    logic [15:0] xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_valid;
    bit          m_y;
    int          m_sel;
    logic [7:0]  m_ack;
    logic [15:0] m_cnt;
    int          m_ptr;

    rr_mux8to1 #(.DATA_W(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .req      (req),
        .ack      (ack),
        .Y        (Y),
        .sel      (sel),
        .valid    (valid),
        .ready    (ready),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        int w = -1;
        for (int o = 0; o < 8; o++)
            if (w < 0 && r[(p + o) % 8]) w = (p + o) % 8;
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_y = 0; m_sel = 0; m_ack = 8'd0; m_cnt = 16'd0; m_ptr = 0;
    endtask

    task automatic model_step();
        bit acc;
        int w;
        acc   = m_valid && (ready === 1'b1);
        m_ack = 8'd0;
        if (acc) begin
            m_ptr = (m_sel + 1) % 8;
            m_cnt = m_cnt + 16'd1;
        end
        if (!m_valid || acc) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_valid = 1;
                m_sel   = w;
                m_y     = D[w];
                m_ack   = 8'd1 << w;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
        chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
        chk({tag, "_Y"}, 32'(Y), 32'(m_y));
        chk({tag, "_ack"}, 32'(ack), 32'(m_ack));
        chk({tag, "_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
        chk({tag, "_ack_onehot0"}, 32'($onehot0(ack)), 32'd1);
    endtask

    // Entered and left at a falling edge.
    task automatic apply(input logic r, input logic [7:0] rq, input logic [7:0] d,
                         input logic rdy, input bit do_chk, input string tag);
        rst = r; req = rq; D = d; ready = rdy;
        if (r) model_reset();
        @(posedge clk);
        if (!r) model_step();
        @(negedge clk);
        if (do_chk) check_model(tag);
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  rq;
        logic [7:0]  d;
        logic        rdy;
        logic        ev;
        logic [2:0]  es;
        logic        ey;
        logic [7:0]  ea;
        logic [15:0] ec;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] a5;
    int         s;

    initial begin
        rst = 1'b1; req = 8'd0; D = 8'd0; ready = 1'b0;
        model_reset();
        a5 = 8'hA5;

        // Single channel, then full round robin from a fresh reset.
        tbl.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 16'd0});
        tbl.push_back('{1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 16'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 1'b1, 8'h00, 16'd1});
        tbl.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 16'd0});
        for (int k = 0; k < 9; k++) begin
            s = k % 8;
            tbl.push_back('{1'b0, 8'hFF, a5, 1'b1, 1'b1, 3'(s), a5[s], 8'd1 << s, 16'(k)});
        end

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].rq, tbl[i].d, tbl[i].rdy, 1, $sformatf("vec%0d_model", i));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].es));
            chk($sformatf("vec%0d_Y", i), 32'(Y), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_cnt", i), 32'(xfer_cnt), 32'(tbl[i].ec));
        end

        // Asynchronous reset while a word is held: outputs clear before any clock edge.
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_ack", 32'(ack), 32'd0);
        chk("async_rst_cnt", 32'(xfer_cnt), 32'd0);
        chk("async_rst_sel", 32'(sel), 32'd0);
        chk("async_rst_Y", 32'(Y), 32'd0);
        @(negedge clk);
        apply(0, 8'h00, 8'hFF, 1, 1, "post_rst0");
        apply(0, 8'h00, 8'h00, 1, 1, "post_rst1");
        chk("post_rst_ack", 32'(ack), 32'd0);

        // Backpressure on channel 3 while D and req churn.
        apply(0, 8'h08, 8'h08, 0, 1, "bp_load");
        chk("bp_load_sel", 32'(sel), 32'd3);
        for (int k = 0; k < 5; k++) begin
            apply(0, 8'($urandom), 8'($urandom), 0, 1, $sformatf("bp%0d", k));
            chk($sformatf("bp%0d_sel", k), 32'(sel), 32'd3);
            chk($sformatf("bp%0d_Y", k), 32'(Y), 32'd1);
            chk($sformatf("bp%0d_ack", k), 32'(ack), 32'd0);
        end
        apply(0, 8'h00, 8'h00, 1, 1, "bp_accept");
        chk("bp_accept_cnt", 32'(xfer_cnt), 32'd1);
        chk("bp_accept_valid", 32'(valid), 32'd0);

        // Pointer wrap: retire channel 6, then 0 wins over 6, then 6.
        apply(1, 8'h00, 8'h00, 0, 1, "pw_rst");
        apply(0, 8'h40, 8'h00, 0, 1, "pw_load6");
        chk("pw_load6_sel", 32'(sel), 32'd6);
        apply(0, 8'h41, 8'h00, 1, 1, "pw_next0");
        chk("pw_next0_sel", 32'(sel), 32'd0);
        apply(0, 8'h41, 8'h00, 1, 1, "pw_next6");
        chk("pw_next6_sel", 32'(sel), 32'd6);

        // Counter wrap: one load edge plus 65535 accepting edges.
        apply(1, 8'h00, 8'h00, 0, 1, "cw_rst");
        for (int k = 0; k < 65536; k++) apply(0, 8'hFF, 8'h5A, 1, 0, "cw");
        chk("cw_preload_cnt", 32'(xfer_cnt), 32'h0000FFFF);
        apply(0, 8'hFF, 8'h5A, 1, 1, "cw_wrap");
        chk("cw_wrap_cnt", 32'(xfer_cnt), 32'd0);
        chk("cw_wrap_valid", 32'(valid), 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            apply(($urandom % 64) == 0,
                  (($urandom % 4) == 0) ? 8'h00 : 8'($urandom),
                  8'($urandom),
                  ($urandom % 4) != 0,
                  1, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
